if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: single-outstanding memory request, IF/ID output register with stall buffer.
// Define IF_JAL_PREDICT_EN to redirect fetch along accepted JAL instructions (static prediction).
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stop,
    input  logic        jump,
    input  logic [31:0] jump_pc,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] inst_data,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] discard_addr_reg, discard_addr_next;
    logic [31:0] buf_pc_reg, buf_pc_next;
    logic [31:0] buf_inst_reg, buf_inst_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic        valid_reg, valid_next;

    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic        unused_jump_bits;

    assign jump_target      = {jump_pc[31:2], 2'b00};
    assign unused_jump_bits = ^jump_pc[1:0];

`ifdef IF_JAL_PREDICT_EN
    // J-type immediate of the word being accepted this cycle.
    logic [31:0] jal_offset;
    assign jal_offset = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                         imem_rdata[20], imem_rdata[30:21], 1'b0};
    assign next_pc = (imem_rdata[6:0] == 7'b1101111) ? fetch_pc_reg + jal_offset
                                                     : fetch_pc_reg + 32'd4;
`else
    assign next_pc = fetch_pc_reg + 32'd4;
`endif

    // DISCARD keeps presenting the abandoned address until its response drains.
    assign imem_req   = (state_reg == FETCH) || (state_reg == DISCARD);
    assign imem_addr  = (state_reg == DISCARD) ? discard_addr_reg : fetch_pc_reg;
    assign pc         = pc_reg;
    assign inst_data  = inst_reg;
    assign inst_valid = valid_reg;

    always_comb begin
        state_next        = state_reg;
        fetch_pc_next     = fetch_pc_reg;
        discard_addr_next = discard_addr_reg;
        buf_pc_next       = buf_pc_reg;
        buf_inst_next     = buf_inst_reg;
        pc_next           = pc_reg;
        inst_next         = inst_reg;
        valid_next        = valid_reg;

        if (jump) begin
            pc_next       = 32'd0;
            inst_next     = NOP_INST;
            valid_next    = 1'b0;
            buf_pc_next   = 32'd0;
            buf_inst_next = NOP_INST;
            fetch_pc_next = jump_target;
            state_next    = FETCH;
            if (state_reg == FETCH && !imem_ack) begin
                discard_addr_next = fetch_pc_reg;
                state_next        = DISCARD;
            end else if (state_reg == DISCARD && !imem_ack) begin
                state_next = DISCARD;
            end
        end else begin
            case (state_reg)
                BOOT: begin
                    state_next = FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        fetch_pc_next = next_pc;
                        if (stop) begin
                            buf_pc_next   = fetch_pc_reg;
                            buf_inst_next = imem_rdata;
                            state_next    = HOLD;
                        end else begin
                            pc_next    = fetch_pc_reg;
                            inst_next  = imem_rdata;
                            valid_next = 1'b1;
                        end
                    end else if (!stop) begin
                        pc_next    = 32'd0;
                        inst_next  = NOP_INST;
                        valid_next = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stop) begin
                        pc_next    = buf_pc_reg;
                        inst_next  = buf_inst_reg;
                        valid_next = 1'b1;
                        state_next = FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        state_next = FETCH;
                    end
                    if (!stop) begin
                        pc_next    = 32'd0;
                        inst_next  = NOP_INST;
                        valid_next = 1'b0;
                    end
                end
                default: begin
                    state_next = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= BOOT;
            fetch_pc_reg     <= RESET_PC;
            discard_addr_reg <= 32'd0;
            buf_pc_reg       <= 32'd0;
            buf_inst_reg     <= NOP_INST;
            pc_reg           <= 32'd0;
            inst_reg         <= NOP_INST;
            valid_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            fetch_pc_reg     <= fetch_pc_next;
            discard_addr_reg <= discard_addr_next;
            buf_pc_reg       <= buf_pc_next;
            buf_inst_reg     <= buf_inst_next;
            pc_reg           <= pc_next;
            inst_reg         <= inst_next;
            valid_reg        <= valid_next;
        end
    end

endmodule
